// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int EMPTY_B = 0;
  localparam int FULL_B  = 1;
  localparam int BUSY_B  = 2;
  localparam int OVF_B   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus UART transmitter: TXDATA/STATUS window, TX FIFO and an 8N1 serializer.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);

  logic          hit, sel_status, wr_txdata, wr_status;
  logic          overflow, unused_bits;
  logic [31:0]   status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;

  tx_state_t     state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          baud_done, tx_n;

  assign hit         = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign sel_status  = (DataAdr[2] == STATUS_OFS[2]);
  assign wr_txdata   = MemWrite & hit & (DataAdr[2] == TXDATA_OFS[2]);
  assign wr_status   = MemWrite & hit & sel_status;
  assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow looks at the count before any same-edge pop, so a full FIFO drops the byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     overflow <= 1'b0;
    else if (wr_txdata && fifo_count == CNT_FULL)   overflow <= 1'b1;
    else if (wr_status && WriteData[OVF_B])         overflow <= 1'b0;
  end

  assign busy = (state != IDLE) | ~fifo_empty;

  always_comb begin
    status          = '0;
    status[EMPTY_B] = fifo_empty;
    status[FULL_B]  = fifo_full;
    status[BUSY_B]  = busy;
    status[OVF_B]   = overflow;
    ReadData        = (hit && sel_status) ? status : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  assign baud_done = (baud_cnt == '0);

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    fifo_pop   = 1'b0;
    baud_cnt_n = baud_cnt;
    if (state != IDLE) baud_cnt_n = baud_done ? BAUD_TC : baud_cnt - BAUD_ONE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_n    = fifo_dout;
          baud_cnt_n = BAUD_TC;
          state_n    = START;
        end
      end
      START: begin
        if (baud_done) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Back-to-back frames: reload straight into START with no idle bit.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_dout;
            state_n  = START;
          end else begin
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level queue model checked every cycle, UART monitor, directed pins.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_F000;
  localparam int          C     = 4;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        tx, busy;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the start time of the frame currently on the wire.
  logic [7:0] mq[$];
  bit         m_act   = 1'b0;
  bit         m_ovf   = 1'b0;
  longint     m_t     = 0;
  longint     m_start = 0;
  logic [7:0] m_byte  = 8'h00;

  function automatic bit in_window(input logic [31:0] a);
    return (a >> 3) == (BASE >> 3);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      m_t   = 0;
    end else begin
      bit was_full;
      m_t++;
      was_full = (mq.size() == DEPTH);
      if (m_act && (m_t - m_start) == 10 * C) m_act = 1'b0;
      if (!m_act && mq.size() != 0) begin
        m_byte  = mq.pop_front();
        m_start = m_t;
        m_act   = 1'b1;
      end
      if (MemWrite && in_window(DataAdr)) begin
        if (!DataAdr[2]) begin
          if (was_full) m_ovf = 1'b1;
          else          mq.push_back(WriteData[7:0]);
        end else if (WriteData[3]) begin
          m_ovf = 1'b0;
        end
      end
    end
  end

  function automatic logic model_tx();
    longint k;
    if (!m_act) return 1'b1;
    k = (m_t - m_start) / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_rdata();
    logic [31:0] st;
    logic        b;
    b  = m_act || (mq.size() != 0);
    st = {28'b0, m_ovf, b, (mq.size() == DEPTH), (mq.size() == 0)};
    if (!in_window(DataAdr)) return 32'h0;
    return DataAdr[2] ? st : 32'h0;
  endfunction

  always @(negedge clk) begin
    chk("tx", tx, model_tx());
    chk("busy", busy, m_act || (mq.size() != 0));
    chk("rdata", ReadData, model_rdata());
  end

  // Independent serial-line decoder, sampling each bit in its middle.
  logic [7:0] rxq[$];
  bit         mon_en     = 1'b1;
  int         rst_events = 0;
  always @(negedge reset) rst_events++;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin : frame
        int         ev;
        logic [7:0] b;
        ev = rst_events;
        repeat (C + C/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          repeat (C) @(negedge clk);
        end
        if (ev == rst_events) begin
          chk("stop_bit", tx, 1'b1);
          rxq.push_back(b);
        end
        repeat (C/2 - 1) @(negedge clk);
      end
    end
  end

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wd;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, budget);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] pat;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = BASE + 32'd4;
    WriteData = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_status", ReadData, 32'h1);
    reset = 1'b1;

    // Single 0x55 frame: start, LSB-first data, stop.
    pat = 10'b1_0101_0101_0;
    drive(1'b1, BASE, 32'h55);
    drive(1'b0, BASE + 32'd4, 32'h0);
    @(negedge clk);
    chk("latency_pre", tx, 1'b1);
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge clk);
      chk("frame55", tx, pat[k / C]);
      if (k == 10 * C - 1) chk("busy_last_bit", busy, 1'b1);
    end
    @(negedge clk);
    chk("busy_after_frame", busy, 1'b0);
    chk("rx55", (rxq.size() == 1) ? rxq[0] : 8'hxx, 8'h55);

    // Ten back-to-back stores into an 8-deep FIFO: the tenth is dropped.
    rxq.delete();
    for (int v = 0; v < 10; v++) drive(1'b1, BASE, 32'(v));
    drive(1'b0, BASE + 32'd4, 32'h0);
    @(negedge clk);
    chk("status_burst", ReadData, 32'hE);
    drive(1'b1, BASE + 32'd4, 32'h8);
    drive(1'b0, BASE + 32'd4, 32'h0);
    @(negedge clk);
    chk("status_ovf_clr", ReadData, 32'h6);
    wait_idle(1000);
    chk("burst_count", rxq.size(), 9);
    for (int i = 0; i < 9; i++) chk("burst_byte", (i < rxq.size()) ? rxq[i] : 8'hxx, 8'(i));

    // Filtered accesses must not start a frame.
    rxq.delete();
    drive(1'b1, BASE + 32'd8, 32'h12);
    drive(1'b1, BASE - 32'd4, 32'h34);
    drive(1'b0, BASE, 32'h56);
    drive(1'b0, BASE + 32'd4, 32'h0);
    repeat (60) @(negedge clk);
    chk("filter_frames", rxq.size(), 0);
    chk("filter_status", ReadData, 32'h1);

    // Reset in the middle of the second frame's data bits.
    rxq.delete();
    drive(1'b1, BASE, 32'hA5);
    drive(1'b1, BASE, 32'h3C);
    drive(1'b0, BASE + 32'd4, 32'h0);
    repeat (50) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_tx", tx, 1'b1);
    chk("async_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_status", ReadData, 32'h1);
    repeat (120) @(negedge clk);
    chk("post_reset_frames", rxq.size(), 1);
    chk("post_reset_byte", (rxq.size() == 1) ? rxq[0] : 8'hxx, 8'hA5);

    // Randomized traffic at three store densities, with occasional resets.
    mon_en = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 800; n++) begin : rnd
        int          r, pct;
        logic [31:0] a, wd;
        pct = (ph == 0) ? 5 : (ph == 1) ? 25 : 70;
        r   = int'($urandom_range(0, 99));
        wd  = $urandom;
        if (r < pct) begin
          drive(1'b1, BASE + 32'($urandom_range(0, 3)), wd);
        end else begin
          case ($urandom_range(0, 9))
            0: drive(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), wd);
            1: begin
                 case ($urandom_range(0, 2))
                   0:       a = BASE + 32'd8 + 32'd4 * 32'($urandom_range(0, 3));
                   1:       a = BASE - 32'd4 * 32'($urandom_range(1, 4));
                   default: a = $urandom;
                 endcase
                 drive(1'b1, a, wd);
               end
            2, 3, 4: drive(1'b0, BASE + 32'($urandom_range(0, 7)), wd);
            5:       drive(1'b0, $urandom, wd);
            default: drive(1'b0, BASE + 32'd4, wd);
          endcase
        end
        reset = ($urandom_range(0, 599) != 0);
      end
    end
    drive(1'b0, BASE + 32'd4, 32'h0);
    reset = 1'b1;
    wait_idle(2 * (DEPTH + 1) * 10 * C + 100);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
